uart_tx_sched: RTL

Two-requester transmit scheduler for the single memory-mapped UART transmitter. The CPU store path (writes to TX data offset 0x8) and the hardware debug/console engine each push bytes into a private FIFO. The scheduler arbitrates round-robin, with an optional bounded lock for the debug side, and drives the UART transmitter's valid/ready byte interface. The CPU's TX-control readback (bit 0 at offset 0x0) comes from `cpu_wr_ready` instead of the raw transmitter ready.

---
 rtl/uart_sched_pkg.sv | 23 ++
 rtl/uart_byte_fifo.sv | 62 ++++++
 rtl/uart_tx_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler slice.
package uart_sched_pkg;

  // Scheduler FSM: IDLE picks a requester, SEND offers one byte to the UART.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Grant encoding, also used for the "last served" bookkeeping.
  localparam logic GR_CPU = 1'b0;
  localparam logic GR_DBG = 1'b1;

  // MMIO register offsets inside the UART region.
  localparam logic [3:0] TX_CTRL = 4'h0;
  localparam logic [3:0] RX_CTRL = 4'h4;
  localparam logic [3:0] TX_DATA = 4'h8;
  localparam logic [3:0] RX_DATA = 4'hC;

  // Region tag carried on address bits [31:28] for the UART block.
  localparam logic [3:0] UART_REGION = 4'h8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO, one per requester. Head byte is always visible on o_data.
module uart_byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == DEPTH[CW-1:0]);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler between the CPU store path and the debug engine,
// feeding a single UART transmitter through a valid/ready byte port.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int LOCK_MAX = 16,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wr_valid,
  input  logic [7:0]    cpu_wr_data,
  output logic          cpu_wr_ready,
  input  logic          dbg_wr_valid,
  input  logic [7:0]    dbg_wr_data,
  output logic          dbg_wr_ready,
  input  logic          dbg_lock,
  output logic [7:0]    uart_din,
  output logic          uart_din_valid,
  input  logic          uart_din_ready,
  output logic [CW-1:0] cpu_count,
  output logic [CW-1:0] dbg_count,
  output logic          busy
);

  state_t     r_state;
  logic       r_grant;
  logic       r_last_grant;
  logic [7:0] r_lock_cnt;
  logic [7:0] r_uart_din;
  logic       r_uart_din_valid;

  logic [7:0] w_cpu_data;
  logic [7:0] w_dbg_data;
  logic       w_cpu_full;
  logic       w_cpu_empty;
  logic       w_dbg_full;
  logic       w_dbg_empty;
  logic       w_accept;
  logic       w_cpu_pop;
  logic       w_dbg_pop;
  logic       w_lock_ok;
  logic       w_pick;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cpu_wr_valid),
    .i_data  (cpu_wr_data),
    .i_pop   (w_cpu_pop),
    .o_data  (w_cpu_data),
    .o_count (cpu_count),
    .o_full  (w_cpu_full),
    .o_empty (w_cpu_empty)
  );

  uart_byte_fifo #(.DEPTH(DEPTH)) u_dbg_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (dbg_wr_valid),
    .i_data  (dbg_wr_data),
    .i_pop   (w_dbg_pop),
    .o_data  (w_dbg_data),
    .o_count (dbg_count),
    .o_full  (w_dbg_full),
    .o_empty (w_dbg_empty)
  );

  assign w_accept  = (r_state == SEND) && uart_din_ready;
  assign w_cpu_pop = w_accept && (r_grant == GR_CPU);
  assign w_dbg_pop = w_accept && (r_grant == GR_DBG);

  // Debug may keep the line only while it was served last and under budget.
  assign w_lock_ok = (r_last_grant == GR_DBG) && dbg_lock && !w_dbg_empty &&
                     (r_lock_cnt < LOCK_MAX[7:0]);

  // Pick the next requester: lock override, then alternate on a tie.
  always_comb begin
    w_pick = GR_CPU;
    if (w_lock_ok) begin
      w_pick = GR_DBG;
    end else if (!w_cpu_empty && !w_dbg_empty) begin
      w_pick = ~r_last_grant;
    end else if (!w_dbg_empty) begin
      w_pick = GR_DBG;
    end
  end

  // FSM with registered byte/valid; the offered byte is frozen until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_grant          <= GR_CPU;
      r_last_grant     <= GR_DBG;
      r_uart_din       <= 8'h00;
      r_uart_din_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_cpu_empty || !w_dbg_empty) begin
            r_state          <= SEND;
            r_grant          <= w_pick;
            r_uart_din       <= (w_pick == GR_DBG) ? w_dbg_data : w_cpu_data;
            r_uart_din_valid <= 1'b1;
          end
        end
        SEND: begin
          if (uart_din_ready) begin
            r_state          <= IDLE;
            r_last_grant     <= r_grant;
            r_uart_din_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_uart_din_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count consecutive locked debug bytes sent while the CPU is kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= 8'h00;
    end else if (!dbg_lock || w_cpu_pop) begin
      r_lock_cnt <= 8'h00;
    end else if (w_dbg_pop && !w_cpu_empty && (r_lock_cnt != 8'hFF)) begin
      r_lock_cnt <= r_lock_cnt + 8'h01;
    end
  end

  assign uart_din       = r_uart_din;
  assign uart_din_valid = r_uart_din_valid;
  assign cpu_wr_ready   = !w_cpu_full;
  assign dbg_wr_ready   = !w_dbg_full;
  assign busy           = (r_state != IDLE) || !w_cpu_empty || !w_dbg_empty;

endmodule
